rf_write_arbiter: RTL
=====================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of write requesters; legal range 2..4.
REQ-002 Parameter ADDR_WIDTH, default 3: register address width in bits.
REQ-003 Parameter DATA_WIDTH, default 16: register data width in bits.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, asynchronous assert, active-low (0 = reset).
REQ-006 flush  input  1: synchronous; while 1, blocks all grants.
REQ-007 req_valid  input  N_REQ: bit i set means requester i has a pending write.
REQ-008 req_addr  input  N_REQ*ADDR_WIDTH: packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 req_data  input  N_REQ*DATA_WIDTH: packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 req_ready  output  N_REQ: one-hot or zero grant, combinational.
REQ-011 w_en  output  1: registered write enable to the register file.
REQ-012 w_addr  output  ADDR_WIDTH: registered write address.
REQ-013 w_data  output  DATA_WIDTH: registered write data.
REQ-014 w_src  output  2: registered index of the requester that owns the current write.
REQ-015 q_addr  input  ADDR_WIDTH: forwarding query address.
REQ-016 fwd_hit  output  1: combinational, w_en && (w_addr == q_addr).
REQ-017 fwd_data  output  DATA_WIDTH: combinational; equals w_data when fwd_hit = 1, else 0.

Function
REQ-018 Transfer on requester i: req_valid[i] && req_ready[i] at a rising edge.
REQ-019 Grant selection:
- Round-robin search starting at pointer ptr, wrapping at N_REQ-1 -> 0.
- The first requester found with req_valid set receives req_ready.
- At most one req_ready bit is set per cycle.
REQ-020 Ready rules:
- req_ready[i] = 0 whenever req_valid[i] = 0, flush = 1, or rst = 0.
- req_ready does not depend on any other condition; the arbiter never back-pressures a granted requester.
REQ-021 Pointer update:
- After a transfer from requester k, ptr becomes (k+1) mod N_REQ.
- With no transfer, ptr holds.
REQ-022 Write stage timing:
- A transfer in cycle t produces w_en = 1 during cycle t+1, with w_addr, w_data and w_src captured from requester k.
- Latency is exactly 1 cycle.
REQ-023 w_en = 0 in every cycle that does not follow a transfer.
REQ-024 w_addr, w_data and w_src hold their last values when w_en = 0.
REQ-025 Sustained throughput is one write per cycle; consecutive transfers produce back-to-back w_en pulses.
REQ-026 Same-address transfers in consecutive cycles issue both writes in order. The arbiter performs no coalescing or reordering.
REQ-027 Flush:
- flush = 1 in cycle t suppresses grants in cycle t, so w_en = 0 in cycle t+1.
- A write already registered in cycle t still completes.
REQ-028 Forwarding covers only the in-flight write. fwd_hit = 1 exactly when the register file will be updated at the end of the current cycle at q_addr.
REQ-029 Requester protocol:
- req_valid and payload remain stable until the transfer.
- Violation behaviour is undefined and not checked.

Reset
REQ-030 rst = 0 asynchronously forces ptr = 0, w_en = 0, w_addr = 0, w_data = 0 and w_src = 0, and holds all req_ready at 0.
REQ-031 A write registered before reset assertion is discarded: w_en drops immediately.
REQ-032 After rst deasserts, the first grant searches from requester 0.

Verification
REQ-033 Reset: drive rst = 0 mid-write (w_en = 1, w_addr = 5) -> w_en = 0 and w_addr = 0 before the next edge; after release, all valid requesters asserted -> requester 0 granted first.
REQ-034 Fairness: all 3 requesters held valid for 6 cycles -> grant order 0,1,2,0,1,2; w_en = 1 in cycles 2..7 with matching w_src.
REQ-035 Sparse requests: only requester 2 valid (addr 3, data 0xBEEF) -> req_ready[2] = 1 in the same cycle; next cycle w_en = 1, w_addr = 3, w_data = 0xBEEF, w_src = 2; ptr then points to 0.
REQ-036 Flush: all requesters valid, flush = 1 for 2 cycles -> req_ready = 0, and w_en = 0 in the 2 following cycles; arbitration then resumes from the unchanged ptr.
REQ-037 Forwarding: write in flight to addr 4 with data 0x1234, q_addr = 4 -> fwd_hit = 1, fwd_data = 0x1234; q_addr = 5 -> fwd_hit = 0, fwd_data = 0.
REQ-038 Same-address ordering: requester 0 writes addr 1 = 0x0001, then requester 1 writes addr 1 = 0x0002 in the next cycle -> two w_en pulses in that order, with final register file value 0x0002.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter that merges N_REQ register-file write requesters into a single
// registered write port, with a bypass of the in-flight write for readers.
module rf_write_arbiter #(
  parameter int unsigned N_REQ      = 3,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        w_en,
  output logic [ADDR_WIDTH-1:0]       w_addr,
  output logic [DATA_WIDTH-1:0]       w_data,
  output logic [1:0]                  w_src,
  input  logic [ADDR_WIDTH-1:0]       q_addr,
  output logic                        fwd_hit,
  output logic [DATA_WIDTH-1:0]       fwd_data
);

  logic [1:0]            ptr_q, ptr_d;
  logic [3:0]            valid_ext;
  logic [3:0]            grant_ext;
  logic [2:0]            idx;
  logic [1:0]            gnt_idx;
  logic                  found;
  logic                  grant_en;
  logic                  transfer;
  logic                  w_en_q;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [1:0]            w_src_q;

  assign valid_ext = 4'(req_valid);

  // Search from ptr upward, wrapping at N_REQ-1; first valid requester wins.
  always_comb begin
    grant_ext = '0;
    gnt_idx   = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = 3'(ptr_q) + 3'(i);
      if (idx >= 3'(N_REQ)) idx = idx - 3'(N_REQ);
      if (!found && valid_ext[idx[1:0]]) begin
        found              = 1'b1;
        grant_ext[idx[1:0]] = 1'b1;
        gnt_idx            = idx[1:0];
      end
    end
  end

  assign grant_en  = rst && !flush;
  assign req_ready = grant_en ? grant_ext[N_REQ-1:0] : '0;
  assign transfer  = grant_en && found;

  always_comb begin
    ptr_d    = ptr_q;
    w_addr_d = req_addr[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    w_data_d = req_data[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    if (transfer) begin
      ptr_d = (gnt_idx == 2'(N_REQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_src_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      w_en_q <= transfer;
      // Payload holds while idle so the write port stays stable.
      if (transfer) begin
        w_addr_q <= w_addr_d;
        w_data_q <= w_data_d;
        w_src_q  <= gnt_idx;
      end
    end
  end

  assign w_en     = w_en_q;
  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;
  assign w_src    = w_src_q;
  assign fwd_hit  = w_en_q && (w_addr_q == q_addr);
  assign fwd_data = fwd_hit ? w_data_q : '0;

endmodule
